// File: rtl/idex_stage.sv
// rtl/idex_stage.sv - ID/EX pipeline register with valid, stall, flush, bubble counter; optional HAZARD_DETECT_EN load-use detection
module idex_stage #(
  parameter int DATA_W       = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int WB_W         = 2,
  parameter int M_W          = 3,
  parameter int EX_W         = 8,
  parameter int MEM_READ_BIT = 0,
  parameter int CNT_W        = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic [WB_W-1:0]       wb_in,
  input  logic [M_W-1:0]        m_in,
  input  logic [EX_W-1:0]       ex_in,
  input  logic [DATA_W-1:0]     reg_rs_in,
  input  logic [DATA_W-1:0]     reg_rt_in,
  input  logic [DATA_W-1:0]     imm_in,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [REG_ADDR_W-1:0] addr_rs_in,
  input  logic [REG_ADDR_W-1:0] addr_rt_in,
  input  logic [REG_ADDR_W-1:0] addr_rd_in,
  output logic                  valid_out,
  output logic [WB_W-1:0]       wb_out,
  output logic [M_W-1:0]        m_out,
  output logic [EX_W-1:0]       ex_out,
  output logic [DATA_W-1:0]     reg_rs_out,
  output logic [DATA_W-1:0]     reg_rt_out,
  output logic [DATA_W-1:0]     imm_out,
  output logic [DATA_W-1:0]     pc_out,
  output logic [REG_ADDR_W-1:0] addr_rs_out,
  output logic [REG_ADDR_W-1:0] addr_rt_out,
  output logic [REG_ADDR_W-1:0] addr_rd_out,
  output logic [CNT_W-1:0]      bubble_count,
  output logic                  hazard_stall
);

  // The mem-read flag has to live inside the M bundle.
  if (MEM_READ_BIT >= M_W) begin : g_bad_mem_read_bit
    $error("MEM_READ_BIT must index into the M control bundle");
  end

  logic                  r_valid;
  logic [WB_W-1:0]       r_wb;
  logic [M_W-1:0]        r_m;
  logic [EX_W-1:0]       r_ex;
  logic [DATA_W-1:0]     r_rs;
  logic [DATA_W-1:0]     r_rt;
  logic [DATA_W-1:0]     r_imm;
  logic [DATA_W-1:0]     r_pc;
  logic [REG_ADDR_W-1:0] r_ars;
  logic [REG_ADDR_W-1:0] r_art;
  logic [REG_ADDR_W-1:0] r_ard;
  logic [CNT_W-1:0]      r_cnt;

  logic w_hazard;
  logic w_bubble_written;

`ifdef HAZARD_DETECT_EN
  // A valid load in EX whose destination feeds the instruction now in decode.
  assign w_hazard = r_valid & r_m[MEM_READ_BIT] & valid_in & (r_art != '0) &
                    ((r_art == addr_rs_in) | (r_art == addr_rt_in));
`else
  assign w_hazard = 1'b0;
`endif

  // A bubble lands in the stage on flush, on a self-inserted hazard bubble,
  // or when an invalid decode slot is loaded; a stall writes nothing.
  assign w_bubble_written = flush | (~stall & (w_hazard | ~valid_in));

  // Pipeline fields: reset > flush > stall > hazard > load.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_wb    <= '0;
      r_m     <= '0;
      r_ex    <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_imm   <= '0;
      r_pc    <= '0;
      r_ars   <= '0;
      r_art   <= '0;
      r_ard   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_wb    <= '0;
      r_m     <= '0;
      r_ex    <= '0;
    end else if (stall) begin
      r_valid <= r_valid;
    end else if (w_hazard) begin
      r_valid <= 1'b0;
      r_wb    <= '0;
      r_m     <= '0;
      r_ex    <= '0;
    end else begin
      r_valid <= valid_in;
      r_wb    <= valid_in ? wb_in : '0;
      r_m     <= valid_in ? m_in  : '0;
      r_ex    <= valid_in ? ex_in : '0;
      r_rs    <= reg_rs_in;
      r_rt    <= reg_rt_in;
      r_imm   <= imm_in;
      r_pc    <= pc_in;
      r_ars   <= addr_rs_in;
      r_art   <= addr_rt_in;
      r_ard   <= addr_rd_in;
    end
  end

  // Saturating count of bubbles written into the stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_bubble_written && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign valid_out    = r_valid;
  assign wb_out       = r_wb;
  assign m_out        = r_m;
  assign ex_out       = r_ex;
  assign reg_rs_out   = r_rs;
  assign reg_rt_out   = r_rt;
  assign imm_out      = r_imm;
  assign pc_out       = r_pc;
  assign addr_rs_out  = r_ars;
  assign addr_rt_out  = r_art;
  assign addr_rd_out  = r_ard;
  assign bubble_count = r_cnt;
  assign hazard_stall = w_hazard;

endmodule

// File: tb/tb_idex_stage.sv
// tb/tb_idex_stage.sv - table-driven bench for idex_stage, plus saturation and load-use sequences
module tb_idex_stage;

`ifdef HAZARD_DETECT_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1, stall = 1'b0, flush = 1'b0, valid_in = 1'b0;
  logic [1:0]  wb_in = '0;
  logic [2:0]  m_in = '0;
  logic [7:0]  ex_in = '0;
  logic [31:0] reg_rs_in = '0, reg_rt_in = '0, imm_in = '0, pc_in = '0;
  logic [4:0]  addr_rs_in = '0, addr_rt_in = '0, addr_rd_in = '0;

  logic        valid_out, hazard_stall;
  logic [1:0]  wb_out;
  logic [2:0]  m_out;
  logic [7:0]  ex_out;
  logic [31:0] reg_rs_out, reg_rt_out, imm_out, pc_out;
  logic [4:0]  addr_rs_out, addr_rt_out, addr_rd_out;
  logic [15:0] bubble_count;

  logic        s_reset = 1'b1, s_stall = 1'b0, s_flush = 1'b0;
  logic        s_valid_out, s_hazard_stall;
  logic [1:0]  s_wb_out;
  logic [2:0]  s_m_out;
  logic [7:0]  s_ex_out;
  logic [31:0] s_rs_out, s_rt_out, s_imm_out, s_pc_out;
  logic [4:0]  s_ars_out, s_art_out, s_ard_out;
  logic [1:0]  s_count;

  int n_pass = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  idex_stage dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
    .wb_in(wb_in), .m_in(m_in), .ex_in(ex_in),
    .reg_rs_in(reg_rs_in), .reg_rt_in(reg_rt_in), .imm_in(imm_in), .pc_in(pc_in),
    .addr_rs_in(addr_rs_in), .addr_rt_in(addr_rt_in), .addr_rd_in(addr_rd_in),
    .valid_out(valid_out), .wb_out(wb_out), .m_out(m_out), .ex_out(ex_out),
    .reg_rs_out(reg_rs_out), .reg_rt_out(reg_rt_out), .imm_out(imm_out), .pc_out(pc_out),
    .addr_rs_out(addr_rs_out), .addr_rt_out(addr_rt_out), .addr_rd_out(addr_rd_out),
    .bubble_count(bubble_count), .hazard_stall(hazard_stall)
  );

  idex_stage #(.CNT_W(2)) u_sat (
    .clock(clock), .reset(s_reset), .stall(s_stall), .flush(s_flush), .valid_in(valid_in),
    .wb_in(wb_in), .m_in(m_in), .ex_in(ex_in),
    .reg_rs_in(reg_rs_in), .reg_rt_in(reg_rt_in), .imm_in(imm_in), .pc_in(pc_in),
    .addr_rs_in(addr_rs_in), .addr_rt_in(addr_rt_in), .addr_rd_in(addr_rd_in),
    .valid_out(s_valid_out), .wb_out(s_wb_out), .m_out(s_m_out), .ex_out(s_ex_out),
    .reg_rs_out(s_rs_out), .reg_rt_out(s_rt_out), .imm_out(s_imm_out), .pc_out(s_pc_out),
    .addr_rs_out(s_ars_out), .addr_rt_out(s_art_out), .addr_rd_out(s_ard_out),
    .bubble_count(s_count), .hazard_stall(s_hazard_stall)
  );

  typedef struct packed {
    logic        rst, stl, fls, vin;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [7:0]  ex;
    logic [31:0] rs, rt, imm, pc;
    logic [4:0]  ars, art, ard;
  } in_t;

  typedef struct packed {
    logic        v;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [7:0]  ex;
    logic [31:0] rs, rt, imm, pc;
    logic [4:0]  ars, art, ard;
    logic [15:0] cnt;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input in_t d);
    reset = d.rst; stall = d.stl; flush = d.fls; valid_in = d.vin;
    wb_in = d.wb; m_in = d.m; ex_in = d.ex;
    reg_rs_in = d.rs; reg_rt_in = d.rt; imm_in = d.imm; pc_in = d.pc;
    addr_rs_in = d.ars; addr_rt_in = d.art; addr_rd_in = d.ard;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_out(input string tag, input out_t e);
    check({tag, " valid_out"},    {31'd0, valid_out},    {31'd0, e.v});
    check({tag, " wb_out"},       {30'd0, wb_out},       {30'd0, e.wb});
    check({tag, " m_out"},        {29'd0, m_out},        {29'd0, e.m});
    check({tag, " ex_out"},       {24'd0, ex_out},       {24'd0, e.ex});
    check({tag, " reg_rs_out"},   reg_rs_out,            e.rs);
    check({tag, " reg_rt_out"},   reg_rt_out,            e.rt);
    check({tag, " imm_out"},      imm_out,               e.imm);
    check({tag, " pc_out"},       pc_out,                e.pc);
    check({tag, " addr_rs_out"},  {27'd0, addr_rs_out},  {27'd0, e.ars});
    check({tag, " addr_rt_out"},  {27'd0, addr_rt_out},  {27'd0, e.art});
    check({tag, " addr_rd_out"},  {27'd0, addr_rd_out},  {27'd0, e.ard});
    check({tag, " bubble_count"}, {16'd0, bubble_count}, {16'd0, e.cnt});
  endtask

  initial begin
    // reset twice with live-looking inputs
    vecs[0]  = '{'{1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 3'd7, 8'hFF, 32'hDEAD, 32'hBEEF, 32'h1, 32'hDEAD, 5'd1, 5'd2, 5'd3},
                 '{1'b0, 2'd0, 3'd0, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 16'd0}};
    vecs[1]  = vecs[0];
    // first load after reset
    vecs[2]  = '{'{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 8'hA5, 32'h0, 32'h0, 32'hFFFFFFF0, 32'h40, 5'd0, 5'd0, 5'd0},
                 '{1'b1, 2'd0, 3'd0, 8'hA5, 32'h0, 32'h0, 32'hFFFFFFF0, 32'h40, 5'd0, 5'd0, 5'd0, 16'd0}};
    // load pc 0x10, then stall three cycles with pc_in 0x14
    vecs[3]  = '{'{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 8'h01, 32'h0, 32'h0, 32'h0, 32'h10, 5'd0, 5'd0, 5'd0},
                 '{1'b1, 2'd0, 3'd0, 8'h01, 32'h0, 32'h0, 32'h0, 32'h10, 5'd0, 5'd0, 5'd0, 16'd0}};
    vecs[4]  = '{'{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 3'd0, 8'h02, 32'h0, 32'h0, 32'h0, 32'h14, 5'd0, 5'd0, 5'd0},
                 vecs[3].o};
    vecs[5]  = vecs[4];
    vecs[6]  = vecs[4];
    vecs[7]  = '{'{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 8'h02, 32'h0, 32'h0, 32'h0, 32'h14, 5'd0, 5'd0, 5'd0},
                 '{1'b1, 2'd0, 3'd0, 8'h02, 32'h0, 32'h0, 32'h0, 32'h14, 5'd0, 5'd0, 5'd0, 16'd0}};
    // full valid load, then flush and stall together
    vecs[8]  = '{'{1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 3'd2, 8'h3C, 32'h1234, 32'h99, 32'h7, 32'h18, 5'd1, 5'd2, 5'd3},
                 '{1'b1, 2'd3, 3'd2, 8'h3C, 32'h1234, 32'h99, 32'h7, 32'h18, 5'd1, 5'd2, 5'd3, 16'd0}};
    vecs[9]  = '{'{1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 3'd1, 8'hFF, 32'hBEEF, 32'hAA, 32'h8, 32'h1C, 5'd7, 5'd8, 5'd9},
                 '{1'b0, 2'd0, 3'd0, 8'h00, 32'h1234, 32'h99, 32'h7, 32'h18, 5'd1, 5'd2, 5'd3, 16'd1}};
    // invalid decode slot: controls gated, data captured
    vecs[10] = '{'{1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 3'd7, 8'hFF, 32'h66, 32'h55, 32'h0, 32'h20, 5'd4, 5'd5, 5'd6},
                 '{1'b0, 2'd0, 3'd0, 8'h00, 32'h66, 32'h55, 32'h0, 32'h20, 5'd4, 5'd5, 5'd6, 16'd2}};
    // reset wins over simultaneous flush and stall
    vecs[11] = '{'{1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 3'd7, 8'hFF, 32'h1, 32'h2, 32'h3, 32'h4, 5'd1, 5'd1, 5'd1},
                 vecs[0].o};

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].i);
      tick();
      check_out($sformatf("row%0d", i), vecs[i].o);
    end

    // load-use: valid lw in the stage writing r8
    drive('{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 3'b001, 8'h11, 32'h100, 32'h200, 32'h4, 32'h24, 5'd3, 5'd8, 5'd8});
    tick();
    check("lw valid_out", {31'd0, valid_out}, 32'd1);
    check("lw addr_rt_out", {27'd0, addr_rt_out}, 32'd8);
    drive('{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'b000, 8'h22, 32'h300, 32'h0, 32'h0, 32'h28, 5'd8, 5'd9, 5'd10});
    #1;
    check("hazard comb", {31'd0, hazard_stall}, {31'd0, HZ});
    stall = 1'b1;
    #1;
    check("hazard ignores stall", {31'd0, hazard_stall}, {31'd0, HZ});
    stall = 1'b0;
    tick();
    check("hz valid_out", {31'd0, valid_out}, HZ ? 32'd0 : 32'd1);
    check("hz wb_out", {30'd0, wb_out}, 32'd0);
    check("hz m_out", {29'd0, m_out}, 32'd0);
    check("hz ex_out", {24'd0, ex_out}, HZ ? 32'h0 : 32'h22);
    check("hz pc_out", pc_out, HZ ? 32'h24 : 32'h28);
    check("hz bubble_count", {16'd0, bubble_count}, HZ ? 32'd1 : 32'd0);
    check("hazard after bubble", {31'd0, hazard_stall}, 32'd0);
    tick();
    check("post-hz pc_out", pc_out, 32'h28);
    check("post-hz valid_out", {31'd0, valid_out}, 32'd1);

    // load whose destination is r0 never triggers the hazard
    drive('{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 3'b001, 8'h33, 32'h0, 32'h0, 32'h0, 32'h2C, 5'd0, 5'd0, 5'd0});
    tick();
    drive('{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 3'b000, 8'h44, 32'h0, 32'h0, 32'h0, 32'h30, 5'd0, 5'd0, 5'd1});
    #1;
    check("r0 hazard comb", {31'd0, hazard_stall}, 32'd0);
    tick();
    check("r0 pc_out", pc_out, 32'h30);
    check("r0 valid_out", {31'd0, valid_out}, 32'd1);
    check("r0 wb_out", {30'd0, wb_out}, 32'd2);
    check("r0 bubble_count", {16'd0, bubble_count}, HZ ? 32'd1 : 32'd0);

    // saturation on the 2-bit counter instance
    check("sat reset count", {30'd0, s_count}, 32'd0);
    s_reset = 1'b0;
    s_flush = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("sat flush%0d count", k + 1), {30'd0, s_count}, (k < 3) ? k + 1 : 3);
      check($sformatf("sat flush%0d valid", k + 1), {31'd0, s_valid_out}, 32'd0);
    end
    s_flush = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/idex_stage.md
Name: idex_stage

Overview:
- Parametrised ID/EX pipeline register for the pipelined MIPS datapath. Sits between the decode and execute stages.
- Adds the following over a plain capture register: a valid bit, stall (hold), flush (bubble insert), gating of control fields by validity, and a saturating bubble counter.
- Optional built-in load-use hazard detection.

Parameters:
- DATA_W, 32, width of the register operands, immediate and PC.
- REG_ADDR_W, 5, width of the register-file addresses.
- WB_W, 2, width of the writeback control bundle.
- M_W, 3, width of the memory control bundle.
- EX_W, 8, width of the execute control bundle.
- MEM_READ_BIT, 0, index of the mem-read flag within the M bundle.
- CNT_W, 16, width of bubble_count.

Ports:
- clock  in  1  single rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold all outputs this cycle
- flush  in  1  write a bubble this cycle
- valid_in  in  1  the decode-stage instruction is real
- wb_in  in  WB_W  writeback controls
- m_in  in  M_W  memory controls
- ex_in  in  EX_W  execute controls
- reg_rs_in, reg_rt_in, imm_in, pc_in  in  DATA_W each  operands, sign-extended immediate, PC
- addr_rs_in, addr_rt_in, addr_rd_in  in  REG_ADDR_W each  register addresses
- valid_out  out  1  registered valid
- wb_out, m_out, ex_out  out  WB_W / M_W / EX_W  registered controls
- reg_rs_out, reg_rt_out, imm_out, pc_out  out  DATA_W  registered data
- addr_rs_out, addr_rt_out, addr_rd_out  out  REG_ADDR_W  registered addresses
- bubble_count  out  CNT_W  number of bubbles written, saturating
- hazard_stall  out  1  load-use stall request to IF/ID and PC; constant 0 when the feature is off

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: at the clock edge with reset=1, every registered output, including bubble_count, goes to 0. Reset overrides every other input.
- Per-edge priority: reset > flush > stall > hazard > load.
- Flush:
  - valid_out <= 0; wb_out, m_out and ex_out <= 0.
  - Data and address outputs keep their previous values.
  - bubble_count increments.
  - Flush wins over a simultaneous stall.
- Stall (flush=0): every output, including bubble_count, holds.
- Hazard: only when HAZARD_DETECT_EN is defined and hazard_stall=1, with stall=0 and flush=0.
  - Same register update as a flush.
  - bubble_count increments.
- Load (none of the above):
  - Every field captures its input; valid_out <= valid_in.
  - If valid_in=0, wb_out, m_out and ex_out are forced to 0 while data fields still capture, and bubble_count increments.
- Latency: exactly 1 cycle from input to output on a load.
- bubble_count: saturates at all-ones and never wraps.
- Control-field invariant: a stage with valid_out=0 never carries nonzero control.
- hazard_stall: purely combinational from the current outputs and inputs; it never depends on stall or flush.

Optional Feature:
- Macro HAZARD_DETECT_EN.
- Defined: hazard_stall = valid_out & m_out[MEM_READ_BIT] & valid_in & (addr_rt_out != 0) & ((addr_rt_out == addr_rs_in) | (addr_rt_out == addr_rt_in)). When it is asserted, the block inserts its own bubble as described above, and upstream holds IF/ID and PC.
- Undefined: hazard_stall is tied to 0, no comparator logic is present, and hazard priority never applies.

Test Plan:
- Reset then load:
  - Stimulus: reset for 2 cycles; then valid_in=1, pc_in=0x00000040, ex_in=0xA5, imm_in=0xFFFFFFF0.
  - Required: all outputs 0 while reset; on the next edge pc_out=0x40, ex_out=0xA5, imm_out=0xFFFFFFF0, valid_out=1, bubble_count=0.
- Stall hold:
  - Stimulus: load pc_in=0x10; then stall=1 for 3 cycles with pc_in=0x14.
  - Required: pc_out stays 0x10 and bubble_count is unchanged; after stall drops, pc_out=0x14 on the next edge.
- Flush beats stall:
  - Stimulus: valid stage holding wb_out=2'b11 and reg_rs_out=0x1234; apply flush=1 and stall=1 together.
  - Required: valid_out=0, wb/m/ex_out=0, reg_rs_out=0x1234, bubble_count +1.
- Invalid-input gating:
  - Stimulus: valid_in=0, m_in=3'b111, reg_rt_in=0x55.
  - Required: m_out=0, reg_rt_out=0x55, valid_out=0, bubble_count +1.
- Saturation (CNT_W=2):
  - Stimulus: 5 consecutive flushes.
  - Required: bubble_count goes 1, 2, 3, 3, 3.
- Load-use (HAZARD_DETECT_EN defined):
  - Stimulus: stage holds a valid lw with m_out[0]=1 and addr_rt_out=8; input has addr_rs_in=8 and valid_in=1.
  - Required: hazard_stall=1 combinationally; next edge valid_out=0, controls 0, bubble_count +1.
  - Repeat with addr_rt_out=0: hazard_stall=0 and a normal load occurs.
  - Without the macro: hazard_stall=0 always.
